// File: rtl/frogger_pkg.sv
// Shared Frogger constants, lane geometry helpers and the collision FSM state type.
package frogger_pkg;

    localparam int unsigned COORD_W           = 10;
    localparam int unsigned POS_W             = 11;
    localparam int unsigned MAX_LANES         = 4;
    localparam int unsigned TILE_SIZE         = 32;
    localparam int unsigned H_VISIBLE_AREA    = 640;
    localparam int unsigned V_VISIBLE_AREA    = 480;
    localparam int unsigned c_X_BASE_POSITION = 320;
    localparam int unsigned c_Y_BASE_POSITION = 384;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        REPORT,
        HOLDOFF,
        GRACE
    } coll_state_e;

    // Top Y of lane k.
    function automatic logic [COORD_W-1:0] lane_y(input int unsigned first_y, input int unsigned lane);
        return COORD_W'(first_y + lane * TILE_SIZE);
    endfunction

    // Power-on car positions: lanes spread 160 px apart, wrapped to the screen.
    function automatic logic [MAX_LANES*COORD_W-1:0] default_lane_x();
        logic [MAX_LANES*COORD_W-1:0] x;
        x = '0;
        for (int unsigned k = 0; k < MAX_LANES; k++) begin
            x[k*COORD_W +: COORD_W] = COORD_W'((k * 160) % H_VISIBLE_AREA);
        end
        return x;
    endfunction

endpackage

// File: rtl/car_lane.sv
// One car lane: X register stepping left or right with wrap at the screen width.
module car_lane
    import frogger_pkg::*;
#(
    parameter logic [COORD_W-1:0] INIT_X    = '0,
    parameter int unsigned        STEP      = 1,
    parameter bit                 MOVE_LEFT = 1'b0,
    parameter int unsigned        H_AREA    = H_VISIBLE_AREA
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_Step,
    output logic [COORD_W-1:0] o_X
);

    logic [POS_W-1:0]   x_ext;
    logic [COORD_W-1:0] x_next;

    assign x_ext = {1'b0, o_X};

    // Wrapped position after one step; 11-bit math keeps the sum from overflowing.
    always_comb begin
        x_next = o_X;
        if (MOVE_LEFT) begin
            if (x_ext < POS_W'(STEP)) begin
                x_next = COORD_W'(x_ext + POS_W'(H_AREA) - POS_W'(STEP));
            end else begin
                x_next = COORD_W'(x_ext - POS_W'(STEP));
            end
        end else begin
            if (x_ext + POS_W'(STEP) >= POS_W'(H_AREA)) begin
                x_next = COORD_W'(x_ext + POS_W'(STEP) - POS_W'(H_AREA));
            end else begin
                x_next = COORD_W'(x_ext + POS_W'(STEP));
            end
        end
    end

    // Lane position register, advanced by the shared step strobe.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_X <= INIT_X;
        end else if (i_Step) begin
            o_X <= x_next;
        end
    end

endmodule

// File: rtl/frog_collision_checker.sv
// Car lane owner and frog/car overlap detector; emits a one-cycle collision pulse.
// Optional invulnerability window after respawn: define COLLISION_GRACE_EN.
module frog_collision_checker
    import frogger_pkg::*;
#(
    parameter int unsigned                  NUM_LANES    = 4,
    parameter int unsigned                  FIRST_LANE_Y = 96,
    parameter int unsigned                  CAR_WIDTH    = 64,
    parameter int unsigned                  STEP_LIMIT   = 1250000,
    parameter int unsigned                  GRACE_CYCLES = 3125000,
    parameter logic [MAX_LANES*COORD_W-1:0] LANE_INIT_X  = default_lane_x()
) (
    input  logic                         i_Clk,
    input  logic                         i_Rst,
    input  logic [COORD_W-1:0]           i_Frog_X,
    input  logic [COORD_W-1:0]           i_Frog_Y,
    output logic [COORD_W*NUM_LANES-1:0] o_Car_X,
    output logic                         o_Has_Collided,
    output logic [1:0]                   o_Hit_Lane,
    output logic                         o_Busy
);

    localparam int unsigned STEP_CNT_W = (STEP_LIMIT > 1) ? $clog2(STEP_LIMIT) : 1;
    localparam int unsigned IDX_W      = 2;

    coll_state_e             state;
    coll_state_e             state_next;
    logic [STEP_CNT_W-1:0]   step_cnt;
    logic                    step_term;
    logic                    step_pending;
    logic                    car_step;
    logic                    scan_req;
    logic                    scan_start;
    logic                    frog_moved;
    logic                    at_base;
    logic                    grace_done;
    logic [COORD_W-1:0]      frog_x_q;
    logic [COORD_W-1:0]      frog_y_q;
    logic [COORD_W-1:0]      snap_x;
    logic [COORD_W-1:0]      snap_y;
    logic [IDX_W-1:0]        scan_idx;
    logic [COORD_W-1:0]      car_x [NUM_LANES];
    logic [POS_W-1:0]        sel_x;
    logic [COORD_W-1:0]      sel_y;
    logic                    hit;
    logic                    has_collided_d;
    logic                    busy_d;
    logic [1:0]              hit_lane_d;

    // Car lanes, all sharing one step strobe; even lanes run right, odd lanes left.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        car_lane #(
            .INIT_X    (LANE_INIT_X[k*COORD_W +: COORD_W]),
            .STEP      (k + 1),
            .MOVE_LEFT (1'(k % 2)),
            .H_AREA    (H_VISIBLE_AREA)
        ) u_car_lane (
            .i_Clk  (i_Clk),
            .i_Rst  (i_Rst),
            .i_Step (car_step),
            .o_X    (car_x[k])
        );
        assign o_Car_X[k*COORD_W +: COORD_W] = car_x[k];
    end

    assign step_term  = (step_cnt == STEP_CNT_W'(STEP_LIMIT - 1));
    assign frog_moved = (i_Frog_X != frog_x_q) || (i_Frog_Y != frog_y_q);
    assign at_base    = (i_Frog_X == COORD_W'(c_X_BASE_POSITION)) &&
                        (i_Frog_Y == COORD_W'(c_Y_BASE_POSITION));
    assign scan_start = (state == IDLE) && !step_pending && scan_req;

`ifdef COLLISION_GRACE_EN
    localparam int unsigned GRACE_W = (GRACE_CYCLES > 1) ? $clog2(GRACE_CYCLES) : 1;

    logic [GRACE_W-1:0] grace_cnt;

    assign grace_done = (state == GRACE) && (grace_cnt == GRACE_W'(GRACE_CYCLES - 1));
    assign car_step   = step_pending && ((state == IDLE) || (state == GRACE));

    // Invulnerability timer, running only while in GRACE.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            grace_cnt <= '0;
        end else if ((state == GRACE) && !grace_done) begin
            grace_cnt <= grace_cnt + GRACE_W'(1);
        end else begin
            grace_cnt <= '0;
        end
    end
`else
    assign grace_done = 1'b0;
    assign car_step   = step_pending && (state == IDLE);

    // Grace length is meaningful only when the invulnerability window is built in.
    if (GRACE_CYCLES == 0) begin : g_grace_len_ignored
    end
`endif

    // Free-running step timer; a terminal count leaves one step pending until IDLE takes it.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            step_cnt     <= '0;
            step_pending <= 1'b0;
        end else begin
            step_cnt <= step_term ? '0 : step_cnt + STEP_CNT_W'(1);
            if (step_term) begin
                step_pending <= 1'b1;
            end else if (car_step) begin
                step_pending <= 1'b0;
            end
        end
    end

    // Scan request latch plus frog-position history used to spot movement.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            scan_req <= 1'b0;
            frog_x_q <= COORD_W'(c_X_BASE_POSITION);
            frog_y_q <= COORD_W'(c_Y_BASE_POSITION);
        end else begin
            scan_req <= (scan_req && !scan_start) || frog_moved || car_step || grace_done;
            frog_x_q <= i_Frog_X;
            frog_y_q <= i_Frog_Y;
        end
    end

    // Frog snapshot and lane walker for the scan in progress.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            snap_x   <= '0;
            snap_y   <= '0;
            scan_idx <= '0;
        end else if (scan_start) begin
            snap_x   <= i_Frog_X;
            snap_y   <= i_Frog_Y;
            scan_idx <= '0;
        end else if (state == SCAN) begin
            scan_idx <= scan_idx + IDX_W'(1);
        end
    end

    // Overlap test for the lane under the scan index; wrapped car tails are ignored.
    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            if (scan_idx == IDX_W'(k)) begin
                sel_x = {1'b0, car_x[k]};
                sel_y = lane_y(FIRST_LANE_Y, k);
            end
        end
        hit = (snap_y == sel_y) &&
              ({1'b0, snap_x} < sel_x + POS_W'(CAR_WIDTH)) &&
              (sel_x < {1'b0, snap_x} + POS_W'(TILE_SIZE));
    end

    // FSM state register.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (scan_start) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (hit) begin
                    state_next = REPORT;
                end else if (scan_idx == IDX_W'(NUM_LANES - 1)) begin
                    state_next = IDLE;
                end
            end
            REPORT: begin
                state_next = HOLDOFF;
            end
            HOLDOFF: begin
                if (at_base) begin
`ifdef COLLISION_GRACE_EN
                    state_next = GRACE;
`else
                    state_next = IDLE;
`endif
                end
            end
            GRACE: begin
`ifdef COLLISION_GRACE_EN
                if (grace_done) begin
                    state_next = IDLE;
                end
`else
                state_next = IDLE;
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM output decode, taken from the upcoming state so outputs can be registered.
    always_comb begin
        has_collided_d = 1'b0;
        busy_d         = 1'b0;
        hit_lane_d     = o_Hit_Lane;
        if (state_next == REPORT) begin
            has_collided_d = 1'b1;
            hit_lane_d     = scan_idx;
        end
        if (state_next != IDLE) begin
            busy_d = 1'b1;
        end
    end

    // Output registers.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_Has_Collided <= 1'b0;
            o_Hit_Lane     <= '0;
            o_Busy         <= 1'b0;
        end else begin
            o_Has_Collided <= has_collided_d;
            o_Hit_Lane     <= hit_lane_d;
            o_Busy         <= busy_d;
        end
    end

endmodule
